ifetch: RTL
===========

# ifetch

Instruction fetch unit that feeds the `decode` stage. It generates the fetch PC and issues word reads to a synchronous instruction memory. Returned words go into a small instruction buffer, and the buffer head is presented to decode as `o_instr`/`o_imask` together with its PC. The block absorbs decode back-pressure and flushes on a control-flow redirect from the execute stage.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `DEPTH`, 4, instruction buffer entries (power of two, ≥2)

Ports:
- `i_clk`  in  1  clock, all state on rising edge
- `i_rst_n`  in  1  asynchronous active-low reset
- `o_imem_req`  out  1  read request this cycle
- `o_imem_addr`  out  32  word address of request, bits [1:0] always 0
- `i_imem_data`  in  32  read data, valid exactly one cycle after an accepted `o_imem_req`
- `i_stall`  in  1  decode not accepting this cycle
- `i_redirect`  in  1  flush and restart fetch
- `i_redirect_pc`  in  32  new fetch address, bits [1:0] ignored (forced 0)
- `o_instr`  out  32  buffer-head instruction; 32'h0000_0013 (NOP) when buffer empty
- `o_imask`  out  1  `o_instr` valid
- `o_pc`  out  32  PC of `o_instr`; 0 when buffer empty

## Operation
- State:
  - `fetch_pc`
  - `inflight` flag with its PC
  - FIFO of {pc, instr} with `count`
  - read/write pointers, mod DEPTH
- Request rule: `o_imem_req = !i_redirect && (count + inflight - pop) < DEPTH`.
  - `pop = o_imask && !i_stall`.
  - On request: `o_imem_addr = fetch_pc`, `fetch_pc <= fetch_pc + 4`, modulo 2^32.
- Response: the cycle after a request, `i_imem_data` and the request PC are pushed into the FIFO, unless that response is killed.
- Output: combinational from FIFO head. `o_imask = (count != 0)`.
  - Pop when `o_imask && !i_stall`.
  - Push and pop in the same cycle are both performed; count is unchanged.
- Redirect, in the cycle `i_redirect = 1`:
  - no request is issued
  - `count <= 0` and pointers are reset
  - an in-flight response returning in the next cycle is discarded
  - `fetch_pc <= {i_redirect_pc[31:2], 2'b00}`
  - Redirect has priority over pop, push and stall. `o_imask` may still be high in the redirect cycle; downstream must ignore it.
- Stall holds the head entry and `o_pc` stable. Fetch continues until the buffer is full.
- Full: once `count + inflight == DEPTH`, `o_imem_req = 0`. No entry is ever overwritten or dropped except by redirect.

## Timing
- Reset (async assert, any time):
  - `fetch_pc = RESET_PC`, `count = 0`, `inflight = 0`
  - `o_imem_req = 0` while asserted
  - `o_imask = 0`, `o_instr = 32'h0000_0013`, `o_pc = 0`
  - An in-flight response is lost.
- First edge after release: request at `RESET_PC` (`o_imem_req` high combinationally in the cycle after release).
- Latency: a request in cycle N gives data pushed at the end of N+1, visible on `o_instr` in N+2.
- Redirect at cycle R: first request at `i_redirect_pc` in R+1; first valid `o_imask` in R+3.
- Steady state with no stall: one instruction per cycle, no bubbles.
- Wrap: `fetch_pc` at 32'hFFFF_FFFC increments to 32'h0000_0000 with no special handling.

## Test plan
- Reset/idle: hold `i_rst_n = 0` for 3 cycles -> `o_imask = 0`, `o_instr = 32'h0000_0013`, `o_pc = 0`, `o_imem_req = 0`. After release, first `o_imem_addr = 0`.
- Streaming: memory model holds 0:32'hfe010113, 4:32'h00112e23, 8:32'h01c0006f, and `i_stall = 0` -> `o_instr` shows these three words on consecutive cycles starting 2 cycles after the first request, with `o_pc` 0, 4, 8.
- Back-pressure/full: `i_stall = 1` from the first valid cycle -> `o_imem_req` drops after exactly DEPTH requests, and the head stays 32'hfe010113 @0. Release the stall -> all DEPTH entries drain in order with no loss or duplicates, and fetch resumes at 4·DEPTH.
- Redirect with in-flight and full buffer: `i_redirect = 1`, `i_redirect_pc = 32'h0000_0103` while stalled and full -> next request addr 32'h0000_0100. No old instruction appears after the redirect cycle; first valid output is pc 0x100, 3 cycles later.
- Simultaneous push/pop and wrap: `RESET_PC = 32'hFFFF_FFF8`, no stall -> `o_pc` sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004 with `count` never exceeding 1.
- Reset mid-operation: assert `i_rst_n = 0` asynchronously between edges while the buffer holds 3 entries -> `o_imask` falls immediately. After release, fetch restarts at `RESET_PC` and stale data is not shown.

Source files
------------

// File: rtl/ifetch.sv
// Instruction fetch unit: issues word reads to a synchronous instruction memory,
// buffers the returned words and presents the buffer head to decode.
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_data,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_instr,
    output logic        o_imask,
    output logic [31:0] o_pc
);

    localparam int          PW  = $clog2(DEPTH);
    localparam int          CW  = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   fetch_pc;
    logic          inflight;
    logic [31:0]   inflight_pc;
    logic [CW-1:0] count;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];

    logic          push;
    logic          pop;
    logic [CW:0]   occupancy;
    logic [31:0]   redirect_base;

    assign redirect_base = i_redirect_pc & ~32'h0000_0003;
    assign o_imask       = (count != '0);
    assign pop           = o_imask && !i_stall;
    assign push          = inflight && !i_redirect;

    // Slots already claimed after this cycle's pop; a request only goes out if
    // its response is guaranteed a free entry when it arrives.
    assign occupancy = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);

    // NOTE: gating with i_rst_n keeps the request low for the whole time reset
    // is held, even though the reset state alone would already allow a request.
    assign o_imem_req  = i_rst_n && !i_redirect && (occupancy < (CW+1)'(DEPTH));
    assign o_imem_addr = fetch_pc;

    assign o_instr = o_imask ? instr_mem[rd_ptr] : NOP;
    assign o_pc    = o_imask ? pc_mem[rd_ptr]    : 32'h0000_0000;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= 32'h0000_0000;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else if (i_redirect) begin
            fetch_pc <= redirect_base;
            inflight <= 1'b0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            inflight <= o_imem_req;
            if (o_imem_req) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + 32'd4;
            end
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // NOTE: buffer storage has no reset; count gates every read of it, so stale
    // contents are never visible and the arrays can map onto plain RAM/regfile.
    always_ff @(posedge i_clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= inflight_pc;
            instr_mem[wr_ptr] <= i_imem_data;
        end
    end

endmodule
